// File: rtl/rv_mem_arb.sv
// Two-port arbiter sharing one single-outstanding memory read port.
// Round-robin or fixed-priority grant; responses are routed back to the owner.
module rv_mem_arb #(
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        s0_req_valid,
    output logic        s0_req_ready,
    input  logic [31:0] s0_req_addr,
    output logic        s0_resp_valid,
    input  logic        s0_resp_ready,
    output logic [31:0] s0_resp_rdata,

    input  logic        s1_req_valid,
    output logic        s1_req_ready,
    input  logic [31:0] s1_req_addr,
    output logic        s1_resp_valid,
    input  logic        s1_resp_ready,
    output logic [31:0] s1_resp_rdata,

    output logic        m_req_valid,
    input  logic        m_req_ready,
    output logic [31:0] m_req_addr,
    input  logic        m_resp_valid,
    output logic        m_resp_ready,
    input  logic [31:0] m_resp_rdata,

    output logic        owner,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_owner;
    logic        r_last_grant;
    logic        r_mreq_valid;
    logic        r_busy;
    logic [31:0] r_addr;

    logic        w_idle;
    logic        w_wait;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_acc0;
    logic        w_acc1;
    logic        w_own_rready;
    logic        w_resp_done;

    assign w_idle = (r_state == ST_IDLE);
    assign w_wait = (r_state == ST_WAIT);

    // On a tie, round-robin hands the grant to the port that did not win last.
    assign w_gnt0 = s0_req_valid &
                    (~s1_req_valid | FIXED_PRI | r_last_grant);
    assign w_gnt1 = s1_req_valid & ~w_gnt0;

    assign s0_req_ready = w_idle & w_gnt0;
    assign s1_req_ready = w_idle & w_gnt1;

    assign w_acc0 = s0_req_valid & s0_req_ready;
    assign w_acc1 = s1_req_valid & s1_req_ready;

    assign w_own_rready = r_owner ? s1_resp_ready : s0_resp_ready;
    assign w_resp_done  = m_resp_valid & w_own_rready;

    // Response path is a pure pass-through while waiting on memory.
    assign m_resp_ready  = w_wait & w_own_rready;
    assign s0_resp_valid = w_wait & ~r_owner & m_resp_valid;
    assign s1_resp_valid = w_wait &  r_owner & m_resp_valid;
    assign s0_resp_rdata = m_resp_rdata;
    assign s1_resp_rdata = m_resp_rdata;

    assign m_req_valid = r_mreq_valid;
    assign m_req_addr  = r_addr;
    assign owner       = r_owner;
    assign busy        = r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_mreq_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_addr       <= 32'd0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_acc0 | w_acc1) begin
                        r_addr       <= w_acc1 ? s1_req_addr : s0_req_addr;
                        r_owner      <= w_acc1;
                        r_last_grant <= w_acc1;
                        r_mreq_valid <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (m_req_ready) begin
                        r_mreq_valid <= 1'b0;
                        r_state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_resp_done) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_mreq_valid <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv_mem_arb.sv
// Bench for rv_mem_arb: grant table, scoreboarded transactions and
// hand-written corner sequences on a round-robin and a fixed-priority instance.
module tb_rv_mem_arb;

    localparam int N_RAND = 200;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        s0_req_valid  [2];
    logic        s0_req_ready  [2];
    logic [31:0] s0_req_addr   [2];
    logic        s0_resp_valid [2];
    logic        s0_resp_ready [2];
    logic [31:0] s0_resp_rdata [2];
    logic        s1_req_valid  [2];
    logic        s1_req_ready  [2];
    logic [31:0] s1_req_addr   [2];
    logic        s1_resp_valid [2];
    logic        s1_resp_ready [2];
    logic [31:0] s1_resp_rdata [2];
    logic        m_req_valid   [2];
    logic        m_req_ready   [2];
    logic [31:0] m_req_addr    [2];
    logic        m_resp_valid  [2];
    logic        m_resp_ready  [2];
    logic [31:0] m_resp_rdata  [2];
    logic        owner         [2];
    logic        busy          [2];

    rv_mem_arb #(.FIXED_PRI(1'b0)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .s0_req_valid(s0_req_valid[0]), .s0_req_ready(s0_req_ready[0]),
        .s0_req_addr(s0_req_addr[0]), .s0_resp_valid(s0_resp_valid[0]),
        .s0_resp_ready(s0_resp_ready[0]), .s0_resp_rdata(s0_resp_rdata[0]),
        .s1_req_valid(s1_req_valid[0]), .s1_req_ready(s1_req_ready[0]),
        .s1_req_addr(s1_req_addr[0]), .s1_resp_valid(s1_resp_valid[0]),
        .s1_resp_ready(s1_resp_ready[0]), .s1_resp_rdata(s1_resp_rdata[0]),
        .m_req_valid(m_req_valid[0]), .m_req_ready(m_req_ready[0]),
        .m_req_addr(m_req_addr[0]), .m_resp_valid(m_resp_valid[0]),
        .m_resp_ready(m_resp_ready[0]), .m_resp_rdata(m_resp_rdata[0]),
        .owner(owner[0]), .busy(busy[0])
    );

    rv_mem_arb #(.FIXED_PRI(1'b1)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .s0_req_valid(s0_req_valid[1]), .s0_req_ready(s0_req_ready[1]),
        .s0_req_addr(s0_req_addr[1]), .s0_resp_valid(s0_resp_valid[1]),
        .s0_resp_ready(s0_resp_ready[1]), .s0_resp_rdata(s0_resp_rdata[1]),
        .s1_req_valid(s1_req_valid[1]), .s1_req_ready(s1_req_ready[1]),
        .s1_req_addr(s1_req_addr[1]), .s1_resp_valid(s1_resp_valid[1]),
        .s1_resp_ready(s1_resp_ready[1]), .s1_resp_rdata(s1_resp_rdata[1]),
        .m_req_valid(m_req_valid[1]), .m_req_ready(m_req_ready[1]),
        .m_req_addr(m_req_addr[1]), .m_resp_valid(m_resp_valid[1]),
        .m_resp_ready(m_resp_ready[1]), .m_resp_rdata(m_resp_rdata[1]),
        .owner(owner[1]), .busy(busy[1])
    );

    typedef struct {
        bit          port;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        bit d;
        bit v0;
        bit v1;
        bit mr;
        bit e_r0;
        bit e_r1;
    } gvec_t;

    exp_t        sb[$];
    bit          glog[$];
    logic [31:0] mem [64];
    gvec_t       gv [6];

    int          errs = 0;
    int          checks = 0;
    bit          act;
    bit          rv [2];
    logic [31:0] ra [2];
    bit          rr [2];
    bit          rnd;
    bit          hold;
    int          hold_left;
    int          mm_st;
    int          mm_cnt;
    int          mm_delay;
    logic [31:0] mm_addr;
    bit          tb_lg;
    bit          tb_own;
    int          issued;
    int          n_acc;
    int          n_resp;
    int          s1rdy_seen;
    bit          saw_s1rv;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
        end
    endtask

    task automatic zero_in(input bit d);
        s0_req_valid[d] = 1'b0;
        s0_req_addr[d] = 32'd0;
        s0_resp_ready[d] = 1'b0;
        s1_req_valid[d] = 1'b0;
        s1_req_addr[d] = 32'd0;
        s1_resp_ready[d] = 1'b0;
        m_req_ready[d] = 1'b0;
        m_resp_valid[d] = 1'b0;
        m_resp_rdata[d] = 32'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        glog.delete();
        rv[0] = 1'b0; rv[1] = 1'b0;
        rr[0] = 1'b1; rr[1] = 1'b1;
        hold = 1'b0; rnd = 1'b0; hold_left = 0;
        mm_st = 0; mm_cnt = 0; mm_delay = 0;
        tb_lg = 1'b1; tb_own = 1'b0;
        zero_in(1'b0);
        zero_in(1'b1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock of stimulus, full-output comparison and model update.
    task automatic cycle();
        logic q0, q1, mrv, mrr, r0v, r1v, bz, ow, mrv_in;
        logic a0, a1, rh0, rh1;
        logic [31:0] maddr, d0, d1;
        bit idle_e, wait_e, fp, e_r0, e_r1, e_mrv, p;
        exp_t e;
        if (rnd) begin
            for (int i = 0; i < 2; i++) begin
                if (!rv[i] && issued < N_RAND &&
                    $urandom_range(0, 2) == 0) begin
                    rv[i] = 1'b1;
                    ra[i] = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
                    issued++;
                end
                rr[i] = ($urandom_range(0, 3) != 0);
            end
        end
        @(negedge clk);
        s0_req_valid[act] = rv[0];
        s0_req_addr[act] = ra[0];
        s0_resp_ready[act] = rr[0];
        s1_req_valid[act] = rv[1];
        s1_req_addr[act] = ra[1];
        s1_resp_ready[act] = rr[1];
        m_req_ready[act] = (mm_st == 0) && (!rnd || $urandom_range(0, 1) == 1);
        mrv_in = (mm_st == 2);
        m_resp_valid[act] = mrv_in;
        m_resp_rdata[act] = mrv_in ? mem[mm_addr[7:2]] : 32'hDEAD_BEEF;
        #1;
        q0 = s0_req_ready[act];  q1 = s1_req_ready[act];
        mrv = m_req_valid[act];  mrr = m_resp_ready[act];
        r0v = s0_resp_valid[act]; r1v = s1_resp_valid[act];
        bz = busy[act];          ow = owner[act];
        maddr = m_req_addr[act];
        d0 = s0_resp_rdata[act]; d1 = s1_resp_rdata[act];

        idle_e = (sb.size() == 0);
        wait_e = (mm_st != 0);
        fp = act;
        e_r0 = idle_e & rv[0] & (!rv[1] | fp | tb_lg);
        e_r1 = idle_e & rv[1] & !e_r0;
        e_mrv = !idle_e & !wait_e;
        chk("s0_req_ready", q0, e_r0);
        chk("s1_req_ready", q1, e_r1);
        chk("m_req_valid", mrv, e_mrv);
        chk("m_resp_ready", mrr, wait_e & rr[tb_own]);
        chk("s0_resp_valid", r0v, wait_e & mrv_in & !tb_own);
        chk("s1_resp_valid", r1v, wait_e & mrv_in & tb_own);
        chk("busy", bz, !idle_e);
        chk("owner", ow, tb_own);
        if (e_mrv) chk("m_req_addr", maddr, sb[0].addr);
        if (mrv_in) begin
            chk("s0_rdata_bcast", d0, m_resp_rdata[act]);
            chk("s1_rdata_bcast", d1, m_resp_rdata[act]);
        end
        if (act && q1) s1rdy_seen++;
        if (r1v) saw_s1rv = 1'b1;

        a0 = rv[0] & q0;
        a1 = rv[1] & q1;
        if (a0 | a1) begin
            p = !a0;
            e.port = p;
            e.addr = ra[p];
            e.data = mem[ra[p][7:2]];
            sb.push_back(e);
            glog.push_back(p);
            tb_lg = p;
            tb_own = p;
            n_acc++;
            if (hold) begin
                hold_left--;
                if (hold_left <= 0) begin
                    rv[0] = 1'b0;
                    rv[1] = 1'b0;
                end
            end else begin
                rv[p] = 1'b0;
            end
        end
        if (mrv & m_req_ready[act]) begin
            mm_st = 1;
            mm_cnt = rnd ? int'($urandom_range(0, 5)) : mm_delay;
            mm_addr = maddr;
        end else if (mm_st == 1) begin
            if (mm_cnt == 0) mm_st = 2;
            else mm_cnt--;
        end
        if (mrv_in & mrr) mm_st = 0;
        rh0 = r0v & rr[0];
        rh1 = r1v & rr[1];
        if (rh0 | rh1) begin
            if (sb.size() == 0) begin
                chk("resp_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("resp_port", {31'd0, rh1}, {31'd0, e.port});
                chk("resp_data", rh1 ? d1 : d0, e.data);
                n_resp++;
            end
        end
    endtask

    task automatic run_until_idle(input int bound);
        int n;
        n = 0;
        while ((sb.size() != 0 || rv[0] || rv[1] || mm_st != 0 ||
                (rnd && issued < N_RAND)) && n < bound) begin
            cycle();
            n++;
        end
        chk("drain_in_time", (n < bound) ? 1 : 0, 1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++)
            mem[i] = 32'h1357_0000 + 32'(i) * 32'h0001_0025;
        mem[0] = 32'h2001_0005;
        mem[1] = 32'h2002_000A;
        mem[2] = 32'h0022_1820;

        gv[0] = '{d: 1'b0, v0: 1'b0, v1: 1'b0, mr: 1'b1, e_r0: 1'b0, e_r1: 1'b0};
        gv[1] = '{d: 1'b0, v0: 1'b1, v1: 1'b0, mr: 1'b0, e_r0: 1'b1, e_r1: 1'b0};
        gv[2] = '{d: 1'b0, v0: 1'b0, v1: 1'b1, mr: 1'b1, e_r0: 1'b0, e_r1: 1'b1};
        gv[3] = '{d: 1'b0, v0: 1'b1, v1: 1'b1, mr: 1'b0, e_r0: 1'b1, e_r1: 1'b0};
        gv[4] = '{d: 1'b1, v0: 1'b1, v1: 1'b1, mr: 1'b1, e_r0: 1'b1, e_r1: 1'b0};
        gv[5] = '{d: 1'b1, v0: 1'b0, v1: 1'b1, mr: 1'b0, e_r0: 1'b0, e_r1: 1'b1};

        act = 1'b0; issued = 0; n_acc = 0; n_resp = 0; s1rdy_seen = 0;
        saw_s1rv = 1'b0; rnd = 1'b0; hold = 1'b0; mm_st = 0;
        rv[0] = 1'b0; rv[1] = 1'b0; rr[0] = 1'b1; rr[1] = 1'b1;
        ra[0] = 32'd0; ra[1] = 32'd0;
        tb_lg = 1'b1; tb_own = 1'b0;

        // Reset values, including a stray memory response during reset.
        rst_n = 1'b0;
        zero_in(1'b0);
        zero_in(1'b1);
        m_resp_valid[0] = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_outs", {26'd0, m_req_valid[d], m_resp_ready[d], busy[d],
                s0_resp_valid[d], s1_resp_valid[d], owner[d]}, 32'd0);
            chk("rst_maddr", m_req_addr[d], 32'd0);
        end

        // Grant table in IDLE; valids withdrawn before each rising edge.
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            s0_req_valid[gv[i].d] = gv[i].v0;
            s1_req_valid[gv[i].d] = gv[i].v1;
            m_resp_valid[gv[i].d] = gv[i].mr;
            #1;
            chk("tbl_r0", s0_req_ready[gv[i].d], gv[i].e_r0);
            chk("tbl_r1", s1_req_ready[gv[i].d], gv[i].e_r1);
            chk("tbl_stray_resp", {30'd0, m_resp_ready[gv[i].d],
                s0_resp_valid[gv[i].d] | s1_resp_valid[gv[i].d]}, 32'd0);
            #1;
            zero_in(gv[i].d);
        end

        // Single port 0 read of word 0.
        do_reset();
        act = 1'b0;
        rv[0] = 1'b1; ra[0] = 32'h0;
        run_until_idle(50);
        chk("single_n_resp", n_resp, 1);

        // Round-robin alternation with both ports held valid.
        do_reset();
        act = 1'b0;
        hold = 1'b1; hold_left = 4;
        rv[0] = 1'b1; ra[0] = 32'h4;
        rv[1] = 1'b1; ra[1] = 32'h8;
        run_until_idle(100);
        chk("rr_count", glog.size(), 4);
        for (int i = 0; i < 4; i++)
            if (glog.size() > i) chk("rr_order", {31'd0, glog[i]}, i % 2);

        // Fixed priority: port 0 takes every transaction.
        do_reset();
        act = 1'b1;
        s1rdy_seen = 0;
        hold = 1'b1; hold_left = 4;
        rv[0] = 1'b1; ra[0] = 32'h4;
        rv[1] = 1'b1; ra[1] = 32'h8;
        run_until_idle(100);
        chk("fp_count", glog.size(), 4);
        for (int i = 0; i < 4; i++)
            if (glog.size() > i) chk("fp_order", {31'd0, glog[i]}, 0);
        chk("fp_s1_never_ready", s1rdy_seen, 0);

        // Requester backpressure on port 1, then back-to-back port 0.
        do_reset();
        act = 1'b0;
        saw_s1rv = 1'b0;
        rr[1] = 1'b0;
        rv[1] = 1'b1; ra[1] = 32'h8;
        for (int i = 0; i < 20 && !saw_s1rv; i++) cycle();
        chk("bp_seen", saw_s1rv, 1);
        rv[0] = 1'b1; ra[0] = 32'h0;
        repeat (5) begin
            cycle();
            chk("bp_data", s1_resp_rdata[0], 32'h0022_1820);
            chk("bp_busy", busy[0], 1);
            chk("bp_s0_ready", s0_req_ready[0], 0);
        end
        rr[1] = 1'b1;
        cycle();
        chk("bp_done", sb.size(), 0);
        cycle();
        chk("b2b_busy", busy[0], 0);
        chk("b2b_s0_ready", s0_req_ready[0], 1);
        run_until_idle(50);

        // Random traffic against a memory with random waits.
        do_reset();
        act = 1'b0;
        rnd = 1'b1; issued = 0; n_acc = 0; n_resp = 0;
        run_until_idle(20000);
        rnd = 1'b0;
        chk("rand_accepts", n_acc, N_RAND);
        chk("rand_resps", n_resp, N_RAND);

        // Reset while waiting on memory.
        do_reset();
        act = 1'b0;
        mm_delay = 5;
        rv[0] = 1'b1; ra[0] = 32'h4;
        for (int i = 0; i < 20 && mm_st == 0; i++) cycle();
        cycle();
        chk("wait_reached", busy[0], 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_wait_outs", {27'd0, m_req_valid[0], m_resp_ready[0],
            busy[0], s0_resp_valid[0], s1_resp_valid[0]}, 32'd0);
        sb.delete(); glog.delete();
        rv[0] = 1'b0; rv[1] = 1'b0;
        mm_st = 0; mm_delay = 0; tb_lg = 1'b1; tb_own = 1'b0;
        zero_in(1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        s0_req_valid[0] = 1'b1;
        s1_req_valid[0] = 1'b1;
        #1;
        chk("rst_tie_r0", s0_req_ready[0], 1);
        chk("rst_tie_r1", s1_req_ready[0], 0);
        #1;
        zero_in(1'b0);
        rv[0] = 1'b1; ra[0] = 32'h0;
        rv[1] = 1'b1; ra[1] = 32'h8;
        run_until_idle(100);
        chk("rst_tie_count", glog.size(), 2);
        if (glog.size() > 0) chk("rst_tie_first", {31'd0, glog[0]}, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
